// File: rtl/ahb_sample_master_if.sv
// Sample-stream handshake plus AHB-Lite master-side signals of ahb_sample_master.
interface ahb_sample_master_if #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int BIT_PREC = 16
);
    logic signed [BIT_PREC-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [AWIDTH-1:0]          haddr;
    logic [1:0]                 htrans;
    logic                       hwrite;
    logic [2:0]                 hsize;
    logic [2:0]                 hburst;
    logic [DWIDTH-1:0]          hwdata;
    logic                       hready;
    logic                       hresp;

    modport master (
        input  s_data, s_valid, hready, hresp,
        output s_ready, haddr, htrans, hwrite, hsize, hburst, hwdata
    );

    modport slave (
        output s_data, s_valid, hready, hresp,
        input  s_ready, haddr, htrans, hwrite, hsize, hburst, hwdata
    );
endinterface

// File: rtl/ahb_sample_master.sv
// AHB-Lite initiator: buffers signed samples in a FIFO and writes each one as a
// NONSEQ SINGLE word write to TARGET_ADDR, with wait-state and ERROR handling.
module ahb_sample_master #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter int                BIT_PREC    = 16,
    parameter int                DEPTH       = 4,
    parameter logic [AWIDTH-1:0] TARGET_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                err_clr,
    ahb_sample_master_if.master bus,
    output logic                busy,
    output logic                err,
    output logic [15:0]         sent_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_NONSEQ = 2'b10
    } trans_e;

    function automatic logic [DWIDTH-1:0] sext(input logic signed [BIT_PREC-1:0] v);
        return {{(DWIDTH-BIT_PREC){v[BIT_PREC-1]}}, v};
    endfunction

    trans_e                     trans_q, trans_d;
    logic                       dvld_q, dvld_d;
    logic [DWIDTH-1:0]          hwdata_q, hwdata_d;
    logic                       err_q, err_d;
    logic [15:0]                sent_q, sent_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]             count_q, count_d;
    logic [PTR_W:0]             remain;
    logic signed [BIT_PREC-1:0] mem_q [DEPTH];
    logic                       full, push, pop, err_hit;

    assign full    = (count_q == FULL_CNT);
    assign push    = bus.s_valid && !full;
    // The presented NONSEQ is accepted, and its sample popped, on any hready edge.
    assign pop     = bus.hready && (trans_q == TR_NONSEQ);
    assign err_hit = !bus.hready && bus.hresp;
    assign remain  = count_q - (PTR_W+1)'(pop);

    always_comb begin
        trans_d  = trans_q;
        dvld_d   = dvld_q;
        hwdata_d = hwdata_q;
        err_d    = err_q;
        sent_d   = sent_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        if (bus.hready) begin
            trans_d = (en && !err_q && (remain != '0)) ? TR_NONSEQ : TR_IDLE;
            dvld_d  = pop;
            if (pop) begin
                hwdata_d = sext(mem_q[rd_ptr_q]);
            end
            if (dvld_q && !bus.hresp) begin
                sent_d = sent_q + 16'd1;
            end
        end else if (bus.hresp) begin
            // First ERROR cycle: withdraw any pending address phase without popping.
            trans_d = TR_IDLE;
        end

        if (err_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trans_q  <= TR_IDLE;
            dvld_q   <= 1'b0;
            hwdata_q <= '0;
            err_q    <= 1'b0;
            sent_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            trans_q  <= trans_d;
            dvld_q   <= dvld_d;
            hwdata_q <= hwdata_d;
            err_q    <= err_d;
            sent_q   <= sent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready = !full;
    assign bus.haddr   = TARGET_ADDR;
    assign bus.htrans  = trans_q;
    assign bus.hwrite  = (trans_q == TR_NONSEQ);
    assign bus.hsize   = 3'b010;
    assign bus.hburst  = 3'b000;
    assign bus.hwdata  = hwdata_q;

    assign busy       = (count_q != '0) || dvld_q;
    assign err        = err_q;
    assign sent_count = sent_q;
endmodule
